riscv_alu_mul_serial: RTL

RISCV_ALU_MUL_SERIAL -- requirements
Module: riscv_alu_mul_serial

---
 rtl/riscv_alu_mul_pkg.sv | 33 +++
 rtl/riscv_alu_cond_neg.sv | 20 ++
 rtl/riscv_alu_mul_serial.sv | 127 ++++++++++++
 3 files changed

// File: rtl/riscv_alu_mul_pkg.sv
// ============================================================================
// Module      : riscv_alu_mul_pkg
// Description : Shared opcode/state types for the serial RISC-V multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_alu_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FINISH = 2'd2
  } mul_state_e;

  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MULH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu_cond_neg.sv
// ============================================================================
// Module      : riscv_alu_cond_neg
// Description : Conditional two's-complement negate of a C_WIDTH-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu_cond_neg #(
  parameter int C_WIDTH = 32
) (
  input  logic               i_neg,
  input  logic [C_WIDTH-1:0] i_data,
  output logic [C_WIDTH-1:0] o_data
);

  assign o_data = i_neg ? ('0 - i_data) : i_data;

endmodule

`default_nettype wire

// File: rtl/riscv_alu_mul_serial.sv
// ============================================================================
// Module      : riscv_alu_mul_serial
// Description : Shift-and-add multiplier for mul/mulh/mulhsu/mulhu.
//               Optional macro RISCV_MUL_SERIAL_EARLY_EXIT_EN ends the loop
//               as soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu_mul_serial
  import riscv_alu_mul_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic               Clk_CI,
  input  logic               Rst_SI,
  input  logic [C_WIDTH-1:0] OpA_DI,
  input  logic [C_WIDTH-1:0] OpB_DI,
  input  logic [1:0]         OpCode_SI,
  input  logic               InVld_SI,
  output logic               InRdy_SO,
  output logic               OutVld_SO,
  input  logic               OutRdy_SI,
  output logic [C_WIDTH-1:0] Res_DO
);

  localparam logic [C_LOG_WIDTH-1:0] C_CNT_INIT = C_LOG_WIDTH'(C_WIDTH - 1);
  localparam logic [C_LOG_WIDTH-1:0] C_CNT_ONE  = C_LOG_WIDTH'(1);

  mul_state_e               r_state, w_state_next;
  mul_op_e                  w_op_in, r_op;
  logic [2*C_WIDTH-1:0]     r_a, r_prod, w_res_full;
  logic [C_WIDTH:0]         r_b, w_b_shift, w_mag_a, w_mag_b;
  logic [C_LOG_WIDTH-1:0]   r_cnt;
  logic                     r_res_inv, w_a_neg, w_b_neg, w_accept, w_last;

  assign w_op_in  = mul_op_e'(OpCode_SI);
  assign w_a_neg  = op_a_signed(w_op_in) & OpA_DI[C_WIDTH-1];
  assign w_b_neg  = op_b_signed(w_op_in) & OpB_DI[C_WIDTH-1];
  assign w_accept = (r_state == IDLE) & InVld_SI;
  assign w_b_shift = r_b >> 1;

  // One extra bit so that the magnitude of the most negative value is exact.
  riscv_alu_cond_neg #(.C_WIDTH(C_WIDTH + 1)) u_neg_a (
    .i_neg  (w_a_neg),
    .i_data ({w_a_neg, OpA_DI}),
    .o_data (w_mag_a)
  );

  riscv_alu_cond_neg #(.C_WIDTH(C_WIDTH + 1)) u_neg_b (
    .i_neg  (w_b_neg),
    .i_data ({w_b_neg, OpB_DI}),
    .o_data (w_mag_b)
  );

  riscv_alu_cond_neg #(.C_WIDTH(2 * C_WIDTH)) u_neg_res (
    .i_neg  (r_res_inv),
    .i_data (r_prod),
    .o_data (w_res_full)
  );

`ifdef RISCV_MUL_SERIAL_EARLY_EXIT_EN
  assign w_last = (r_cnt == '0) || (w_b_shift == '0);
`else
  assign w_last = (r_cnt == '0);
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (InVld_SI)  w_state_next = MULT;
      MULT:    if (w_last)    w_state_next = FINISH;
      FINISH:  if (OutRdy_SI) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_comb begin
    InRdy_SO  = 1'b0;
    OutVld_SO = 1'b0;
    case (r_state)
      IDLE:    InRdy_SO  = 1'b1;
      FINISH:  OutVld_SO = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      r_a       <= '0;
      r_b       <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_res_inv <= 1'b0;
      r_op      <= MUL;
    end else if (w_accept) begin
      r_a       <= {{(C_WIDTH-1){1'b0}}, w_mag_a};
      r_b       <= w_mag_b;
      r_prod    <= '0;
      r_cnt     <= C_CNT_INIT;
      r_res_inv <= w_a_neg ^ w_b_neg;
      r_op      <= w_op_in;
    end else if (r_state == MULT) begin
      if (r_b[0]) begin
        r_prod <= r_prod + r_a;
      end
      r_a   <= r_a << 1;
      r_b   <= w_b_shift;
      r_cnt <= r_cnt - C_CNT_ONE;
    end
  end

  assign Res_DO = (r_op == MUL) ? w_res_full[C_WIDTH-1:0]
                                : w_res_full[2*C_WIDTH-1:C_WIDTH];

endmodule

`default_nettype wire
